// File: rtl/piso_bit_serializer.sv
// Parallel-in, serial-out bit serializer with a one-entry holding buffer so
// consecutive words stream out with no idle bit between them.
module piso_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             full_q, full_d;
   logic             ready_q, ready_d;
   logic             sout_q, sout_d;
   logic             svalid_q, svalid_d;
   logic             fdone_q, fdone_d;
   logic [CW-1:0]    cntNext;
   logic             accept;

   // Serial bit k of a word, honouring the configured bit order.
   function automatic logic bitAt(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
      logic [CW-1:0] idx;
      idx = MSB_FIRST ? (LAST - k) : k;
      return w[idx];
   endfunction

   assign accept  = data_valid & ready_q;
   assign cntNext = cnt_q + CW'(1);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      buf_d    = buf_q;
      full_d   = full_q;
      sout_d   = 1'b0;
      svalid_d = 1'b0;
      fdone_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d  = data_in;
               cnt_d    = '0;
               state_d  = SHIFT;
               sout_d   = bitAt(data_in, '0);
               svalid_d = 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q != LAST) begin
               cnt_d    = cntNext;
               sout_d   = bitAt(shift_q, cntNext);
               svalid_d = 1'b1;
               fdone_d  = (cntNext == LAST);
               if (accept) begin
                  buf_d  = data_in;
                  full_d = 1'b1;
               end
            end else if (full_q) begin
               // Buffered word takes priority; ready is low so no accept here.
               shift_d  = buf_q;
               full_d   = 1'b0;
               cnt_d    = '0;
               sout_d   = bitAt(buf_q, '0);
               svalid_d = 1'b1;
            end else if (accept) begin
               shift_d  = data_in;
               cnt_d    = '0;
               sout_d   = bitAt(data_in, '0);
               svalid_d = 1'b1;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = ~full_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         buf_q    <= '0;
         full_q   <= 1'b0;
         ready_q  <= 1'b1;
         sout_q   <= 1'b0;
         svalid_q <= 1'b0;
         fdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         buf_q    <= buf_d;
         full_q   <= full_d;
         ready_q  <= ready_d;
         sout_q   <= sout_d;
         svalid_q <= svalid_d;
         fdone_q  <= fdone_d;
      end
   end

   assign data_ready = ready_q;
   assign sout       = sout_q;
   assign sout_valid = svalid_q;
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed self-checking bench for piso_bit_serializer: MSB-first and
// LSB-first instances plus a "1001" Mealy detector model fed by sout.
module tb_piso_bit_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dataIn = '0;
   logic       dataValid = 1'b0;
   logic       dataReady, sout, soutValid, frameDone;
   logic [7:0] dataInL = '0;
   logic       dataValidL = 1'b0;
   logic       dataReadyL, soutL, soutValidL, frameDoneL;

   int passCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .data_in(dataIn), .data_valid(dataValid),
      .data_ready(dataReady), .sout(sout), .sout_valid(soutValid),
      .frame_done(frameDone)
   );

   piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutL (
      .clk(clk), .rst(rst), .data_in(dataInL), .data_valid(dataValidL),
      .data_ready(dataReadyL), .sout(soutL), .sout_valid(soutValidL),
      .frame_done(frameDoneL)
   );

   // Downstream non-overlapping "1001" detector with a registered pulse output.
   logic [1:0] detState;
   logic       detOut;
   always_ff @(posedge clk) begin
      if (rst) begin
         detState <= 2'd0;
         detOut   <= 1'b0;
      end else begin
         detOut <= 1'b0;
         if (soutValid) begin
            case (detState)
               2'd0: detState <= sout ? 2'd1 : 2'd0;
               2'd1: detState <= sout ? 2'd1 : 2'd2;
               2'd2: detState <= sout ? 2'd1 : 2'd3;
               default: begin
                  detState <= 2'd0;
                  detOut   <= sout;
               end
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkCount++;
      if ({sout, soutValid, frameDone, dataReady} !== 4'b0001)
         $display("[TB] FAIL reset_msb: got %b, expected 0001", {sout, soutValid, frameDone, dataReady});
      else passCount++;
      checkCount++;
      if ({soutL, soutValidL, frameDoneL, dataReadyL} !== 4'b0001)
         $display("[TB] FAIL reset_lsb: got %b, expected 0001", {soutL, soutValidL, frameDoneL, dataReadyL});
      else passCount++;
   endtask

   task automatic test_single();
      logic [7:0] expBits;
      expBits = 8'b10100101;
      dataIn = 8'hA5;
      dataValid = 1'b1;
      tick();
      dataValid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checkCount++;
         if ({sout, soutValid, frameDone} !== {expBits[7-k], 1'b1, (k == 7)})
            $display("[TB] FAIL single_bit%0d: got %b, expected %b", k, {sout, soutValid, frameDone}, {expBits[7-k], 1'b1, (k == 7)});
         else passCount++;
         tick();
      end
      checkCount++;
      if ({sout, soutValid, frameDone} !== 3'b000)
         $display("[TB] FAIL single_idle: got %b, expected 000", {sout, soutValid, frameDone});
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] expBits;
      expBits = 16'b1001000000001001;
      dataIn = 8'h90;
      dataValid = 1'b1;
      tick();
      dataIn = 8'h09;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) tick();
         if (i == 1) dataValid = 1'b0;
         checkCount++;
         if ({sout, soutValid, frameDone} !== {expBits[15-i], 1'b1, (i == 7 || i == 15)})
            $display("[TB] FAIL b2b_bit%0d: got %b, expected %b", i, {sout, soutValid, frameDone}, {expBits[15-i], 1'b1, (i == 7 || i == 15)});
         else passCount++;
         if (i >= 1 && i <= 8) begin
            checkCount++;
            if (dataReady !== (i == 8))
               $display("[TB] FAIL b2b_ready%0d: got %b, expected %b", i, dataReady, (i == 8));
            else passCount++;
         end
      end
      tick();
      checkCount++;
      if (soutValid !== 1'b0)
         $display("[TB] FAIL b2b_idle: got %b, expected 0", soutValid);
      else passCount++;
   endtask

   task automatic test_lsb_first();
      dataInL = 8'h01;
      dataValidL = 1'b1;
      tick();
      dataValidL = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checkCount++;
         if ({soutL, soutValidL} !== {(k == 0), 1'b1})
            $display("[TB] FAIL lsb_bit%0d: got %b, expected %b", k, {soutL, soutValidL}, {(k == 0), 1'b1});
         else passCount++;
         tick();
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] expBits;
      int validSeen;
      dataIn = 8'hFF;
      dataValid = 1'b1;
      tick();
      dataIn = 8'hAA;
      tick();
      dataValid = 1'b0;
      tick();
      checkCount++;
      if ({sout, soutValid, dataReady} !== 3'b110)
         $display("[TB] FAIL midrst_pre: got %b, expected 110", {sout, soutValid, dataReady});
      else passCount++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkCount++;
      if ({sout, soutValid, frameDone, dataReady} !== 4'b0001)
         $display("[TB] FAIL midrst_state: got %b, expected 0001", {sout, soutValid, frameDone, dataReady});
      else passCount++;
      validSeen = 0;
      for (int i = 0; i < 12; i++) begin
         if (soutValid) validSeen++;
         tick();
      end
      checkCount++;
      if (validSeen !== 0)
         $display("[TB] FAIL midrst_discard: got %0d valid cycles, expected 0", validSeen);
      else passCount++;
      expBits = 8'b00111100;
      dataIn = 8'h3C;
      dataValid = 1'b1;
      tick();
      dataValid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checkCount++;
         if ({sout, soutValid, frameDone} !== {expBits[7-k], 1'b1, (k == 7)})
            $display("[TB] FAIL midrst_next%0d: got %b, expected %b", k, {sout, soutValid, frameDone}, {expBits[7-k], 1'b1, (k == 7)});
         else passCount++;
         tick();
      end
   endtask

   task automatic test_direct_reload();
      logic [15:0] expBits;
      expBits = {8'hC3, 8'h5A};
      dataIn = 8'hC3;
      dataValid = 1'b1;
      tick();
      dataValid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checkCount++;
         if ({sout, soutValid, frameDone, dataReady} !== {expBits[15-i], 1'b1, (i == 7 || i == 15), 1'b1})
            $display("[TB] FAIL reload_bit%0d: got %b, expected %b", i, {sout, soutValid, frameDone, dataReady}, {expBits[15-i], 1'b1, (i == 7 || i == 15), 1'b1});
         else passCount++;
         if (i == 7) begin
            dataIn = 8'h5A;
            dataValid = 1'b1;
         end
         tick();
         if (i == 7) dataValid = 1'b0;
      end
      checkCount++;
      if (soutValid !== 1'b0)
         $display("[TB] FAIL reload_idle: got %b, expected 0", soutValid);
      else passCount++;
   endtask

   task automatic test_detector();
      int pulses;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pulses = 0;
      dataIn = 8'h99;
      dataValid = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         tick();
         if (c == 1) dataIn = 8'h00;
         if (c == 2) dataValid = 1'b0;
         if (detOut) pulses++;
         checkCount++;
         if (detOut !== (c == 5 || c == 9))
            $display("[TB] FAIL det_cycle%0d: got %b, expected %b", c, detOut, (c == 5 || c == 9));
         else passCount++;
      end
      checkCount++;
      if (pulses !== 2)
         $display("[TB] FAIL det_count: got %0d, expected 2", pulses);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_lsb_first();
      test_reset_midframe();
      test_direct_reload();
      test_detector();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
Parallel-in, serial-out stage directly upstream of the team's Mealy sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on sout, which drives the detector's single-bit data input. A one-entry holding buffer lets consecutive words stream with no idle bit between them, so bit patterns that span a word boundary reach the detector unbroken. sout is forced to 0 when the stage is idle.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  reset, synchronous and active-high
data_in  input  WIDTH  parallel word to serialize
data_valid  input  1  data_in is valid
data_ready  output  1  stage can accept a word this cycle
sout  output  1  serial bit to the downstream detector
sout_valid  output  1  sout carries a real data bit
frame_done  output  1  pulse in the same cycle sout carries the last bit of a word

Behaviour:
- Handshake: a word is accepted at a rising edge where data_valid=1 and data_ready=1. data_in must be held stable while data_valid=1 and data_ready=0.
- data_ready is a registered output equal to the inverse of the holding-buffer-full flag. It does not depend combinationally on data_valid.
- Internal state:
  - shift register, WIDTH bits
  - bit counter, clog2(WIDTH) bits, range 0..WIDTH-1
  - holding buffer, WIDTH bits, plus a full flag
  - FSM with two states, IDLE and SHIFT
- Reset (rst=1 at an edge), which wins over every other event:
  - state = IDLE, counter = 0, buffer emptied
  - sout = 0, sout_valid = 0, frame_done = 0, data_ready = 1
  - a partly sent word and any buffered word are discarded
- IDLE:
  - sout = 0, sout_valid = 0.
  - On accept at edge N: data_in loads the shift register, counter = 0, state goes to SHIFT.
  - The first bit appears on sout with sout_valid=1 in cycle N+1. Latency is one clock.
- SHIFT:
  - Each edge presents the next bit and increments the counter.
  - A word occupies exactly WIDTH consecutive cycles of sout_valid=1.
  - frame_done=1 only in the cycle that carries bit index WIDTH-1 of the word.
- Accepting during SHIFT:
  - If the counter is not WIDTH-1, the word goes to the holding buffer. The full flag is set and data_ready=0 from the next cycle.
- Last-bit edge (counter = WIDTH-1), resolved in this priority order:
  - Buffer full: the buffer moves into the shift register, the full flag clears, and data_ready=1 next cycle. A new accept cannot occur at this edge because data_ready=0.
  - Buffer empty and an accept occurs: data_in loads the shift register directly and the buffer stays empty.
  - In both cases the counter goes to 0, state stays SHIFT, and the next word's first bit follows in the very next cycle with no gap.
  - Neither case: state goes to IDLE, and sout=0, sout_valid=0 next cycle.
- Bit order:
  - MSB_FIRST=1: bit index k of the serial stream is data_in[WIDTH-1-k].
  - MSB_FIRST=0: bit index k is data_in[k].
- sout, sout_valid and frame_done are all registered. No combinational path runs from any input to any output.
- Throughput: sustained one word per WIDTH cycles with a continuous 100% sout_valid duty cycle.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: release reset, then a single accept of 8'hA5 at edge N. Required: sout=1,0,1,0,0,1,0,1 in cycles N+1..N+8; sout_valid=1 exactly in N+1..N+8; frame_done=1 only in N+8; sout=0 and sout_valid=0 from N+9.
2. Back-to-back: accept 8'h90 at edge N, then hold data_valid=1 with 8'h09.
   - Required: 8'h09 is accepted at N+1 and data_ready=0 in N+2..N+8.
   - The 16 valid bits are 1001000000001001, contiguous over N+1..N+16.
   - frame_done=1 in N+8 and N+16.
   - data_ready=1 again from N+9.
3. MSB_FIRST=0, accept 8'h01. Required: sout=1 in the first valid cycle, then 0 for the next seven valid cycles.
4. Reset mid-frame: accept 8'hFF, buffer 8'hAA, then assert rst after the third bit. Required: the cycle after the reset edge shows sout=0, sout_valid=0, frame_done=0, data_ready=1; 8'hAA is never emitted; the next accepted word serializes normally.
5. Direct reload at last bit: buffer empty and data_valid first asserted at the last-bit edge. Required: the new word is accepted at that edge, its first bit follows with no gap, and the buffer flag stays 0.
6. Integration with the downstream "1001" non-overlapping Mealy detector: send 8'h99 then 8'h00. Required: the detector output pulses exactly twice, in the cycle after serial bit 3 and in the cycle after serial bit 7, each as a one-cycle pulse.
